mano_ac_unit: RTL and testbench
===============================

// Module: mano_ac_unit
// PURPOSE
//   Registered, parametrised accumulator/ALU for the Mano datapath. Holds AC and E
//   internally and executes one register-reference or memory-reference micro-op per
//   accepted request. Adds rotate, increment and a multi-cycle shift-add multiply
//   behind a valid/ready handshake. Sits between the control unit (op issue) and
//   the common bus (DR in, AC out).
// PARAMETERS
//   WIDTH   8   data width of AC, DR and result (>=2)
//   MUL_EN  1   1 = MUL opcode implemented; 0 = MUL executes as NOP
// PORTS
//   clk       in   1      single clock, rising edge
//   rst       in   1      synchronous, active-high reset
//   op_valid  in   1      request valid
//   op_ready  out  1      unit can accept a request this cycle
//   op        in   4      opcode, sampled on accept
//   dr        in   WIDTH  DR operand, sampled on accept
//   ac        out  WIDTH  accumulator register
//   e         out  1      E (carry/link) register
//   done      out  1      one-cycle pulse: result of last accepted op is visible
//   busy      out  1      multiply in progress (== ~op_ready)
//   z         out  1      ac == 0 (combinational from ac)
//   n         out  1      ac[WIDTH-1]
// BEHAVIOUR
//   Reset (clk edge with rst=1): ac=0, e=0, done=0, busy=0, op_ready=1, FSM=IDLE.
//   Reset wins over any concurrent accept; reset during MUL aborts it, no done.
//   Accept = op_valid & op_ready on a rising edge. op_ready=1 in IDLE, 0 in MUL.
//   Opcodes (others -> NOP: ac/e unchanged, done still pulses):
//     0 NOP  1 AND ac&=dr        2 ADD {e,ac}=ac+dr (WIDTH+1-bit sum)
//     3 LDA ac=dr                4 CMA ac=~ac       5 CLA ac=0
//     6 CLE e=0                  7 CME e=~e
//     8 CIR ac={e,ac[W-1:1]}, e=ac[0]   9 CIL ac={ac[W-2:0],e}, e=ac[W-1]
//     10 INC ac=ac+1 mod 2^W, e unchanged
//     11 MUL P=ac*dr (2W bits): ac=P[W-1:0], e=|P[2W-1:W] (overflow flag)
//   Single-cycle ops: ac/e updated at the accept edge; done=1 the following cycle.
//     Back-to-back accepts every cycle allowed; done then stays high continuously.
//   MUL (MUL_EN=1): FSM IDLE -> MUL on accept; operands latched into shadow regs;
//     counter runs WIDTH cycles, one shift-add step per cycle; ac/e keep old value
//     during MUL; result written on the WIDTH-th edge after accept; FSM -> IDLE;
//     done=1 and op_ready=1 in the following cycle. op_valid while busy ignored.
//   Total MUL latency accept-edge to done: WIDTH+1 cycles. Zero operand still takes
//     full WIDTH cycles (fixed latency, no early exit).
//   Wrap: ADD carry-out goes only to e; INC wraps 2^W-1 -> 0 silently.
//   z/n follow ac combinationally, valid in every cycle incl. reset.
// TESTING
//   1 rst=1 2 cycles, op_valid=1 op=LDA dr=8'h55 -> ac=0 e=0 done=0 op_ready=1.
//   2 LDA 8'hF0, ADD dr=8'h20 -> ac=8'h10 e=1 z=0; done high each cycle after accept.
//   3 ac=8'h81 e=0: CIL -> ac=8'h02 e=1; CIR -> ac=8'h81 e=0; CME,CLE -> e=1 then 0.
//   4 ac=8'h0F, MUL dr=8'h11 -> op_ready=0 8 cycles, done on cycle 9: ac=8'hFF e=0.
//   5 ac=8'h10, MUL dr=8'h10 -> ac=8'h00 e=1 z=1; op_valid held high during MUL
//     with op=CLA is not accepted (ac not cleared before MUL result).
//   6 rst asserted 3 cycles into MUL -> ac=0 e=0, no done pulse, op_ready=1 next;
//     MUL_EN=0 build: MUL -> ac/e unchanged, done next cycle, op_ready never drops.

Source files
------------

// File: rtl/mano_ac_unit_if.sv
// Op-issue / result handshake between the control unit and the AC unit.
// The control unit is the master; the AC unit is the slave.
interface mano_ac_unit_if #(
    parameter int WIDTH = 8
);
    logic             op_valid;
    logic             op_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] dr;
    logic [WIDTH-1:0] ac;
    logic             e;
    logic             done;
    logic             busy;
    logic             z;
    logic             n;

    modport master (
        output op_valid, op, dr,
        input  op_ready, ac, e, done, busy, z, n
    );

    modport slave (
        input  op_valid, op, dr,
        output op_ready, ac, e, done, busy, z, n
    );
endinterface

// File: rtl/mano_ac_unit.sv
// Mano accumulator/ALU: AC and E registers, one micro-op per accept,
// plus a fixed-latency shift-add multiply behind the ready handshake.
module mano_ac_unit #(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input logic            clk,
    input logic            rst,
    mano_ac_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, MUL} state_t;

    state_t             state, state_nx;
    logic [WIDTH-1:0]   ac_q, ac_nx;
    logic               e_q, e_nx;
    logic               done_q;
    logic               rdy, bsy;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] mcand, prod, prod_nx;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH:0]     sum;
    logic               accept, is_mul, last;

    assign accept  = bus.op_valid & rdy;
    assign is_mul  = MUL_EN && (bus.op == 4'd11);
    assign last    = (cnt == CW'(WIDTH - 1));
    assign sum     = {1'b0, ac_q} + {1'b0, bus.dr};
    assign prod_nx = prod + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && is_mul) state_nx = MUL;
            MUL:     if (last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rdy = (state == IDLE);
        bsy = (state == MUL);
    end

    always_comb begin
        ac_nx = ac_q;
        e_nx  = e_q;
        case (bus.op)
            4'd1:    ac_nx = ac_q & bus.dr;
            4'd2:    {e_nx, ac_nx} = sum;
            4'd3:    ac_nx = bus.dr;
            4'd4:    ac_nx = ~ac_q;
            4'd5:    ac_nx = '0;
            4'd6:    e_nx = 1'b0;
            4'd7:    e_nx = ~e_q;
            4'd8: begin
                ac_nx = {e_q, ac_q[WIDTH-1:1]};
                e_nx  = ac_q[0];
            end
            4'd9: begin
                ac_nx = {ac_q[WIDTH-2:0], e_q};
                e_nx  = ac_q[WIDTH-1];
            end
            4'd10:   ac_nx = ac_q + 1'b1;
            default: ;
        endcase
    end

    // MUL: one partial product per cycle, result lands on the last step
    always_ff @(posedge clk) begin
        if (rst) begin
            ac_q   <= '0;
            e_q    <= 1'b0;
            done_q <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
        end else begin
            done_q <= 1'b0;
            if (state == MUL) begin
                prod   <= prod_nx;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                if (last) begin
                    ac_q   <= prod_nx[WIDTH-1:0];
                    e_q    <= |prod_nx[2*WIDTH-1:WIDTH];
                    done_q <= 1'b1;
                end
            end else if (accept) begin
                if (is_mul) begin
                    mcand  <= {{WIDTH{1'b0}}, ac_q};
                    mplier <= bus.dr;
                    prod   <= '0;
                    cnt    <= '0;
                end else begin
                    ac_q   <= ac_nx;
                    e_q    <= e_nx;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign bus.op_ready = rdy;
    assign bus.busy     = bsy;
    assign bus.ac       = ac_q;
    assign bus.e        = e_q;
    assign bus.done     = done_q;
    assign bus.z        = (ac_q == '0);
    assign bus.n        = ac_q[WIDTH-1];
endmodule

// File: tb/tb_mano_ac_unit.sv
// Randomised scoreboard bench for mano_ac_unit with directed corner cases.
// A second instance covers the MUL_EN=0 build.
module tb_mano_ac_unit;
    localparam int W  = 8;
    localparam int M  = 2 ** W;
    localparam int TO = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mano_ac_unit_if #(.WIDTH(W)) bus ();
    mano_ac_unit_if #(.WIDTH(W)) bus0 ();

    mano_ac_unit #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    mano_ac_unit #(.WIDTH(W), .MUL_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    int nvec = 0;
    int nerr = 0;
    int mac = 0;
    int me = 0;
    int stale = 0;
    logic [W:0] q[$];
    logic [W:0] exp_r;

    function automatic logic [W:0] model(int op, int dr, int a, int e, bit mulen);
        int na = a;
        int ne = e;
        int s;
        logic [W:0] r;
        case (op)
            1: na = a & dr;
            2: begin s = a + dr; na = s % M; ne = (s >= M) ? 1 : 0; end
            3: na = dr;
            4: na = (M - 1) - a;
            5: na = 0;
            6: ne = 0;
            7: ne = 1 - e;
            8: begin na = e * (M / 2) + a / 2; ne = a % 2; end
            9: begin na = (a * 2) % M + e; ne = a / (M / 2); end
            10: na = (a + 1) % M;
            11: if (mulen) begin
                s = a * dr; na = s % M; ne = (s >= M) ? 1 : 0;
            end
            default: ;
        endcase
        r[W-1:0] = na[W-1:0];
        r[W] = ne[0];
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.done) begin
                nvec++;
                if (q.size() == 0) begin
                    nerr++;
                    $display("FAIL spurious_done actual ac=%h e=%b required no done",
                             bus.ac, bus.e);
                end else begin
                    exp_r = q.pop_front();
                    if ({bus.e, bus.ac} !== exp_r || bus.z !== (exp_r[W-1:0] == 0)
                        || bus.n !== exp_r[W-1]) begin
                        nerr++;
                        $display("FAIL result actual e=%b ac=%h z=%b n=%b required e=%b ac=%h",
                                 bus.e, bus.ac, bus.z, bus.n, exp_r[W], exp_r[W-1:0]);
                    end
                end
                stale = 0;
            end else if (q.size() != 0) begin
                stale++;
                if (stale > W + 3) begin
                    nvec++;
                    nerr++;
                    $display("FAIL done_timeout actual no done required done, pending=%0d",
                             q.size());
                    q.delete();
                    stale = 0;
                end
            end
        end
    end

    task automatic issue(int op, int dr);
        int t = 0;
        logic [W:0] r;
        @(negedge clk);
        while (!bus.op_ready && t < TO) begin
            @(negedge clk);
            t++;
        end
        if (!bus.op_ready) begin
            nvec++;
            nerr++;
            $display("FAIL ready_timeout actual op_ready=0 required 1");
        end
        bus.op_valid = 1'b1;
        bus.op = op[3:0];
        bus.dr = dr[W-1:0];
        r = model(op, dr, mac, me, 1'b1);
        q.push_back(r);
        mac = int'(r[W-1:0]);
        me = int'(r[W]);
        @(posedge clk);
        #1 bus.op_valid = 1'b0;
    endtask

    task automatic mul_watch(int pre_ac, bit hold);
        if (hold) begin
            bus.op_valid = 1'b1;
            bus.op = 4'd5;
        end
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk("mul_busy_ready", bus.op_ready, 0);
            chk("mul_ac_held", bus.ac, pre_ac);
        end
        @(negedge clk);
        bus.op_valid = 1'b0;
        chk("mul_ready_back", bus.op_ready, 1);
        chk("mul_done", bus.done, 1);
    endtask

    initial begin
        bus.op_valid = 1'b1;
        bus.op = 4'd3;
        bus.dr = 8'h55;
        bus0.op_valid = 1'b0;
        bus0.op = 4'd0;
        bus0.dr = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ac", bus.ac, 0);
        chk("rst_e", bus.e, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_ready", bus.op_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_z", bus.z, 1);
        bus.op_valid = 1'b0;
        rst = 1'b0;

        issue(3, 'hF0);
        issue(2, 'h20);
        chk("add_ac", bus.ac, 'h10);
        chk("add_e", bus.e, 1);
        chk("add_z", bus.z, 0);

        issue(3, 'h81);
        issue(6, 0);
        issue(9, 0);
        chk("cil_ac", bus.ac, 'h02);
        chk("cil_e", bus.e, 1);
        issue(8, 0);
        chk("cir_ac", bus.ac, 'h81);
        chk("cir_e", bus.e, 0);
        issue(7, 0);
        chk("cme_e", bus.e, 1);
        issue(6, 0);
        chk("cle_e", bus.e, 0);
        issue(3, 'hFF);
        issue(10, 0);
        chk("inc_wrap_ac", bus.ac, 0);
        chk("inc_wrap_e", bus.e, 0);

        issue(3, 'h0F);
        issue(11, 'h11);
        mul_watch('h0F, 1'b0);
        chk("mul1_ac", bus.ac, 'hFF);
        chk("mul1_e", bus.e, 0);

        issue(3, 'h10);
        issue(11, 'h10);
        mul_watch('h10, 1'b1);
        chk("mul2_ac", bus.ac, 'h00);
        chk("mul2_e", bus.e, 1);
        chk("mul2_z", bus.z, 1);

        issue(3, 'h5A);
        issue(11, 0);
        mul_watch('h5A, 1'b0);
        chk("mul_zero_ac", bus.ac, 0);

        issue(3, 'h3C);
        issue(11, 7);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        mac = 0;
        me = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_ac", bus.ac, 0);
        chk("abort_e", bus.e, 0);
        chk("abort_ready", bus.op_ready, 1);
        chk("abort_done", bus.done, 0);
        repeat (W + 2) @(negedge clk);
        chk("abort_no_done", bus.done, 0);

        @(negedge clk);
        bus0.op_valid = 1'b1;
        bus0.op = 4'd3;
        bus0.dr = 8'hA5;
        @(posedge clk);
        #1 bus0.op_valid = 1'b0;
        chk("nomul_lda", bus0.ac, 'hA5);
        @(negedge clk);
        bus0.op_valid = 1'b1;
        bus0.op = 4'd11;
        bus0.dr = 8'h33;
        @(posedge clk);
        #1 bus0.op_valid = 1'b0;
        chk("nomul_ready", bus0.op_ready, 1);
        @(negedge clk);
        chk("nomul_done", bus0.done, 1);
        chk("nomul_ac", bus0.ac, 'hA5);
        chk("nomul_e", bus0.e, 0);
        chk("nomul_busy", bus0.busy, 0);

        for (int i = 0; i < 300; i++) begin
            int op;
            int dr;
            op = int'($urandom_range(0, 15));
            dr = int'($urandom_range(0, M - 1));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            issue(op, dr);
        end

        for (int t = 0; t < TO && q.size() != 0; t++) @(negedge clk);
        chk("drain", q.size(), 0);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
